pipe_stage_reg: RTL
===================

# pipe_stage_reg

Parametrised, handshaked pipeline-stage register that succeeds the fixed IF/ID register. It carries a payload word plus its PC between two pipeline stages. It adds valid/ready flow control with a two-entry skid so `up_ready_o` is registered, supports multiple OR-ed stall sources, and inserts a configurable bubble on flush. It is instantiated at every inter-stage boundary (IF/ID, ID/EX, EX/MEM, MEM/WB) of the CPU pipeline.

## Interface
Parameters:
- `DATA_W`, default 32: payload width.
- `PC_W`, default 32: PC width.
- `STALL_SRCS`, default 2: number of stall inputs (e.g. hazard unit, cache MemStall).
- `BUBBLE`, default `pipe_pkg::NOP_INSN` (`32'h0000_0013`), truncated/zero-extended to `DATA_W`: value driven on `data_o` after a flush.
- `CNT_W`, default 16: width of the performance counters.

Ports:
- `clk_i` in 1: clock. One clock; reset is synchronous and active-high.
- `rst_i` in 1: synchronous, active-high reset.
- `up_valid_i` in 1: upstream beat valid.
- `up_ready_o` out 1: stage can accept; registered.
- `data_i` in `DATA_W`: upstream payload.
- `pc_i` in `PC_W`: upstream PC.
- `stall_i` in `STALL_SRCS`: any bit high means hold the output.
- `flush_i` in 1: squash the stage contents.
- `dn_valid_o` out 1: output beat valid.
- `dn_ready_i` in 1: downstream accepts.
- `data_o` out `DATA_W`: payload.
- `pc_o` out `PC_W`: PC of the payload.
- `bubble_o` out 1: the current output is a flush-inserted bubble.
- `stall_cnt_o` out `CNT_W`: present only with `PIPE_STAGE_PERF_EN`.
- `flush_cnt_o` out `CNT_W`: present only with `PIPE_STAGE_PERF_EN`.

## Operation
- Storage: an output register (OUT) holding data, pc, valid and bubble, plus a skid register (SKID) holding data, pc and valid.
- `adv = dn_ready_i & ~|stall_i`. OUT is consumed when `dn_valid_o & adv`.
- `acc = up_valid_i & up_ready_o`.
- `up_ready_o` is the registered value of `~SKID.valid`.
- Priority per cycle: `rst_i` > `flush_i` > normal flow.
- Flush:
  - SKID.valid is cleared.
  - OUT is loaded with `data_o=BUBBLE`, `dn_valid_o=1`, `bubble_o=1`; `pc_o` is held.
  - Any `acc` beat in the same cycle is dropped.
  - Flush overrides stall.
- Normal flow, when OUT is empty or consumed:
  - If SKID.valid: OUT takes SKID (`bubble_o=0`) and SKID is cleared.
  - Else if `acc`: OUT takes `data_i`/`pc_i` (`bubble_o=0`).
  - Else: `dn_valid_o` drops to 0; data and pc are held.
- Normal flow, when OUT is full and not consumed: an `acc` beat is written to SKID.
- `acc` while SKID is already full cannot occur, because `up_ready_o` is 0.
- Ordering: beats leave in acceptance order; no duplication, no loss except under flush.
- A bubble is consumed like any other beat.

## Timing
- Reset values (sync reset): `dn_valid_o=0`, `data_o=0`, `pc_o=0`, `bubble_o=0`, `up_ready_o=1`, SKID empty, counters 0.
- Latency `data_i` → `data_o`: 1 cycle when unobstructed.
- Throughput: 1 beat/cycle with `adv` held high.
- After OUT blocks:
  - One further beat is absorbed in SKID.
  - `up_ready_o` falls the cycle after SKID fills.
  - `up_ready_o` rises the cycle after SKID drains.
- Flush takes effect on the next edge; the bubble is visible 1 cycle after `flush_i`.
- Reset mid-stream discards OUT and SKID on the next edge; no partial state survives.

## Configuration
- Macro: `PIPE_STAGE_PERF_EN`.
- Defined:
  - `stall_cnt_o` increments each cycle where `dn_valid_o & ~adv`.
  - `flush_cnt_o` increments each cycle `flush_i` is high.
  - Both saturate at all-ones and clear on `rst_i`.
- Undefined: both counter ports and their logic are absent; flow behaviour is identical.

## Structure
- `pipe_pkg` holds `NOP_INSN` (32'h0000_0013), default widths, and a `stage_beat_t` typedef (data, pc, valid, bubble) for OUT/SKID.
- One sub-module: `pipe_sat_cnt` (`CNT_W` saturating counter with sync clear and enable), instantiated twice under `PIPE_STAGE_PERF_EN`.

## Test plan
- Streaming: `data_i` = 1,2,3,… with `up_valid_i=1` and `adv=1` → `data_o` = 1,2,3,… one cycle later; `up_ready_o` stays 1.
- Backpressure: during streaming, `dn_ready_i=0` for 3 cycles → SKID holds one beat; `up_ready_o=0` from the 2nd stall cycle; on release the output continues in order with no loss or duplication.
- Stall sources: `stall_i=2'b10` with `dn_ready_i=1` → identical to the backpressure case; `data_o`/`pc_o` held.
- Flush: OUT=0x55, SKID full, `flush_i=1` → next cycle `data_o=0x13`, `bubble_o=1`, `dn_valid_o=1`, SKID empty, `up_ready_o=1` one cycle later.
- Flush with stall plus reset: flush while `stall_i≠0` → bubble still inserted. `rst_i` mid-stream → all outputs match the reset values on the next edge.
- Perf (macro on, `CNT_W=4`): hold a stall for 20 cycles → `stall_cnt_o` saturates at 15.

Source files
------------

// File: rtl/pipe_pkg.sv
// pipe_pkg
// Shared constants and beat type for the CPU pipeline-stage registers.
// NOP_INSN is the canonical RISC-V "addi x0, x0, 0" used as the flush bubble.
// Optional feature macro used by the stage register: PIPE_STAGE_PERF_EN.

package pipe_pkg;

  // Canonical no-op instruction word inserted on flush
  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

  // Default widths for a stage register instance
  localparam int DEF_DATA_W     = 32;
  localparam int DEF_PC_W       = 32;
  localparam int DEF_STALL_SRCS = 2;
  localparam int DEF_CNT_W      = 16;

  // One stored beat at default widths: payload, PC, occupancy and bubble flag
  typedef struct packed {
    logic [DEF_DATA_W-1:0] data;
    logic [DEF_PC_W-1:0]   pc;
    logic                  valid;
    logic                  bubble;
  } stage_beat_t;

endpackage : pipe_pkg

// File: rtl/pipe_sat_cnt.sv
// pipe_sat_cnt
// Saturating up-counter with synchronous clear and count enable.
// Once it reaches all-ones it stays there until cleared.

module pipe_sat_cnt
  import pipe_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk_i,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: step by one when enabled unless already saturated
  always_comb begin
    cnt_d = cnt_q;
    if (en_i && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Count register with synchronous clear
  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule : pipe_sat_cnt

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg
// Handshaked pipeline-stage register placed between every pair of CPU stages.
// An output register (OUT) feeds the next stage; a one-beat skid register
// (SKID) absorbs the beat that arrives while OUT is blocked, which lets
// up_ready_o come straight from a flop. Any stall source or a low dn_ready_i
// holds OUT; flush replaces OUT with a bubble and empties SKID.
// Optional feature macro: PIPE_STAGE_PERF_EN adds saturating stall and flush
// counters on stall_cnt_o / flush_cnt_o.

module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int                DATA_W     = DEF_DATA_W,
  parameter int                PC_W       = DEF_PC_W,
  parameter int                STALL_SRCS = DEF_STALL_SRCS,
  parameter logic [DATA_W-1:0] BUBBLE     = DATA_W'(NOP_INSN),
  parameter int                CNT_W      = DEF_CNT_W
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  up_valid_i,
  output logic                  up_ready_o,
  input  logic [DATA_W-1:0]     data_i,
  input  logic [PC_W-1:0]       pc_i,
  input  logic [STALL_SRCS-1:0] stall_i,
  input  logic                  flush_i,
  output logic                  dn_valid_o,
  input  logic                  dn_ready_i,
  output logic [DATA_W-1:0]     data_o,
  output logic [PC_W-1:0]       pc_o,
  output logic                  bubble_o
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [CNT_W-1:0]      stall_cnt_o,
  output logic [CNT_W-1:0]      flush_cnt_o
`endif
);

  // Same shape as pipe_pkg::stage_beat_t, sized by this instance's parameters
  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [PC_W-1:0]   pc;
    logic              valid;
    logic              bubble;
  } beat_t;

  beat_t out_q;
  beat_t out_d;
  beat_t skid_q;
  beat_t skid_d;
  logic  up_ready_q;
  logic  up_ready_d;

  logic  adv;
  logic  consume;
  logic  acc;

  // Handshake terms: the output may advance only when downstream is ready
  // and no stall source is asserted
  always_comb begin
    adv     = dn_ready_i & ~(|stall_i);
    consume = out_q.valid & adv;
    acc     = up_valid_i & up_ready_q;
  end

  // Next state of OUT and SKID; flush beats normal flow, and an accepted beat
  // during flush is intentionally dropped
  always_comb begin
    out_d  = out_q;
    skid_d = skid_q;
    if (flush_i) begin
      skid_d.valid  = 1'b0;
      out_d.data    = BUBBLE;
      out_d.valid   = 1'b1;
      out_d.bubble  = 1'b1;
    end else if (!out_q.valid || consume) begin
      if (skid_q.valid) begin
        out_d.data   = skid_q.data;
        out_d.pc     = skid_q.pc;
        out_d.valid  = 1'b1;
        out_d.bubble = 1'b0;
        skid_d.valid = 1'b0;
      end else if (acc) begin
        out_d.data   = data_i;
        out_d.pc     = pc_i;
        out_d.valid  = 1'b1;
        out_d.bubble = 1'b0;
      end else begin
        out_d.valid  = 1'b0;
        out_d.bubble = 1'b0;
      end
    end else if (acc) begin
      skid_d.data   = data_i;
      skid_d.pc     = pc_i;
      skid_d.valid  = 1'b1;
      skid_d.bubble = 1'b0;
    end
    up_ready_d = ~skid_d.valid;
  end

  // Stage state registers; ready comes from its own flop so upstream sees a
  // clean registered signal
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_q      <= '0;
      skid_q     <= '0;
      up_ready_q <= 1'b1;
    end else begin
      out_q      <= out_d;
      skid_q     <= skid_d;
      up_ready_q <= up_ready_d;
    end
  end

  assign up_ready_o = up_ready_q;
  assign dn_valid_o = out_q.valid;
  assign data_o     = out_q.data;
  assign pc_o       = out_q.pc;
  assign bubble_o   = out_q.bubble;

`ifdef PIPE_STAGE_PERF_EN
  logic stall_evt;
  logic flush_evt;

  // A stall cycle is one where a valid beat sits in OUT but cannot leave
  always_comb begin
    stall_evt = out_q.valid & ~adv;
    flush_evt = flush_i;
  end

  pipe_sat_cnt #(
    .CNT_W(CNT_W)
  ) u_stall_cnt (
    .clk_i (clk_i),
    .clr_i (rst_i),
    .en_i  (stall_evt),
    .cnt_o (stall_cnt_o)
  );

  pipe_sat_cnt #(
    .CNT_W(CNT_W)
  ) u_flush_cnt (
    .clk_i (clk_i),
    .clr_i (rst_i),
    .en_i  (flush_evt),
    .cnt_o (flush_cnt_o)
  );
`endif

endmodule : pipe_stage_reg
